// File: rtl/mips_alu.sv
// MIPS-subset execute-stage ALU: decodes the instruction word, computes a registered
// result with zero/overflow/negative flags, and owns the HI/LO multiply/divide registers.
module mips_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_datain,
  input  logic [31:0] gr1,
  input  logic [31:0] gr2,
  output logic [31:0] c,
  output logic [2:0]  zon,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [5:0]         op;
  logic [5:0]         func;
  logic [4:0]         shamt;
  logic [31:0]        imm_sext;
  logic [31:0]        imm_zext;
  logic               unused_fields;

  logic [31:0]        sum_rr;
  logic [31:0]        diff_rr;
  logic [31:0]        sum_ri;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               div_by_zero;

  logic [31:0]        res;
  logic               ovf;
  logic               flag_en;
  logic               hilo_we;
  logic [31:0]        hi_n;
  logic [31:0]        lo_n;

  assign op            = i_datain[31:26];
  assign func          = i_datain[5:0];
  assign shamt         = i_datain[10:6];
  assign imm_sext      = {{16{i_datain[15]}}, i_datain[15:0]};
  assign imm_zext      = {16'h0000, i_datain[15:0]};
  assign unused_fields = ^i_datain[25:16];

  assign sum_rr  = gr1 + gr2;
  assign diff_rr = gr1 - gr2;
  assign sum_ri  = gr1 + imm_sext;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{gr1[31]}}, gr1} * {{32{gr2[31]}}, gr2};
  assign prod_u = {32'h0, gr1} * {32'h0, gr2};

  assign div_by_zero = (gr2 == 32'h0);
  assign quot_s      = div_by_zero ? 32'sd0 : ($signed(gr1) / $signed(gr2));
  assign rem_s       = div_by_zero ? 32'sd0 : ($signed(gr1) % $signed(gr2));
  assign quot_u      = div_by_zero ? 32'h0 : (gr1 / gr2);
  assign rem_u       = div_by_zero ? 32'h0 : (gr1 % gr2);

  always_comb begin
    res     = 32'h0;
    ovf     = 1'b0;
    flag_en = 1'b1;
    hilo_we = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
    case (op)
      6'h00: begin
        case (func)
          6'h20: begin
            res = sum_rr;
            ovf = (gr1[31] == gr2[31]) && (sum_rr[31] != gr1[31]);
          end
          6'h21: res = sum_rr;
          6'h22: begin
            res = diff_rr;
            ovf = (gr1[31] != gr2[31]) && (diff_rr[31] != gr1[31]);
          end
          6'h23: res = diff_rr;
          6'h24: res = gr1 & gr2;
          6'h25: res = gr1 | gr2;
          6'h26: res = gr1 ^ gr2;
          6'h27: res = ~(gr1 | gr2);
          6'h2A: res = {31'h0, $signed(gr1) < $signed(gr2)};
          6'h2B: res = {31'h0, gr1 < gr2};
          6'h00: res = gr2 << shamt;
          6'h02: res = gr2 >> shamt;
          6'h03: res = $signed(gr2) >>> shamt;
          6'h04: res = gr2 << gr1[4:0];
          6'h06: res = gr2 >> gr1[4:0];
          6'h07: res = $signed(gr2) >>> gr1[4:0];
          6'h18: begin
            flag_en = 1'b0;
            hilo_we = 1'b1;
            {hi_n, lo_n} = prod_s;
          end
          6'h19: begin
            flag_en = 1'b0;
            hilo_we = 1'b1;
            {hi_n, lo_n} = prod_u;
          end
          6'h1A: begin
            flag_en = 1'b0;
            hilo_we = !div_by_zero;
            hi_n    = rem_s;
            lo_n    = quot_s;
          end
          6'h1B: begin
            flag_en = 1'b0;
            hilo_we = !div_by_zero;
            hi_n    = rem_u;
            lo_n    = quot_u;
          end
          default: flag_en = 1'b0;
        endcase
      end
      6'h08: begin
        res = sum_ri;
        ovf = (gr1[31] == imm_sext[31]) && (sum_ri[31] != gr1[31]);
      end
      6'h09, 6'h23, 6'h2B: res = sum_ri;
      6'h0C: res = gr1 & imm_zext;
      6'h0D: res = gr1 | imm_zext;
      6'h0E: res = gr1 ^ imm_zext;
      6'h0A: res = {31'h0, $signed(gr1) < $signed(imm_sext)};
      6'h0B: res = {31'h0, gr1 < imm_sext};
      6'h04, 6'h05: res = diff_rr;
      default: flag_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c   <= 32'h0;
      zon <= 3'b000;
      hi  <= 32'h0;
      lo  <= 32'h0;
    end else begin
      c   <= res;
      zon <= flag_en ? {(res == 32'h0), ovf, res[31]} : 3'b000;
      if (hilo_we) begin
        hi <= hi_n;
        lo <= lo_n;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu: hand-computed vectors covering arithmetic,
// flags, shifts, compares, HI/LO multiply/divide, hold behaviour and async reset.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_datain;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic [31:0] c;
  logic [2:0]  zon;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mips_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_datain (i_datain),
    .gr1      (gr1),
    .gr2      (gr2),
    .c        (c),
    .zon      (zon),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 10'h000, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 10'h000, imm};
  endfunction

  // Drive between edges, then sample 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    i_datain = instr;
    gr1      = a;
    gr2      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] exp_c,
                          input logic [2:0] exp_zon, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    checkOutput({tag, ".c"}, c, exp_c);
    checkOutput({tag, ".zon"}, {29'h0, zon}, {29'h0, exp_zon});
    checkOutput({tag, ".hi"}, hi, exp_hi);
    checkOutput({tag, ".lo"}, lo, exp_lo);
  endtask

  initial begin
    rst_n    = 1'b0;
    i_datain = rtype(6'h20, 5'd0);
    gr1      = 32'h1234_5678;
    gr2      = 32'h1111_1111;
    #23;
    $display("[TB] checking reset state");
    checkAll("reset", 32'h0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] add/sub and flags");
    applyStimulus(rtype(6'h20, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD);
    checkAll("add", 32'h1E1E_1E1D, 3'b000, 32'h0, 32'h0);
    applyStimulus(itype(6'h08, 16'hFFFF), 32'h7FFF_FFFF, 32'h0);
    checkAll("addi_neg", 32'h7FFF_FFFE, 3'b000, 32'h0, 32'h0);
    applyStimulus(rtype(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001);
    checkAll("add_ovf", 32'h8000_0000, 3'b011, 32'h0, 32'h0);
    applyStimulus(rtype(6'h22, 5'd0), 32'h5DDD_DDDD, 32'h5DDD_DDDD);
    checkAll("sub_zero", 32'h0, 3'b100, 32'h0, 32'h0);
    applyStimulus(rtype(6'h22, 5'd0), 32'h8000_0000, 32'h0000_0001);
    checkAll("sub_ovf", 32'h7FFF_FFFF, 3'b010, 32'h0, 32'h0);
    applyStimulus(rtype(6'h21, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001);
    checkAll("addu_noovf", 32'h8000_0000, 3'b001, 32'h0, 32'h0);
    applyStimulus(rtype(6'h23, 5'd0), 32'h8000_0000, 32'h0000_0001);
    checkAll("subu_noovf", 32'h7FFF_FFFF, 3'b000, 32'h0, 32'h0);
    applyStimulus(itype(6'h08, 16'h0001), 32'h7FFF_FFFF, 32'h0);
    checkAll("addi_ovf", 32'h8000_0000, 3'b011, 32'h0, 32'h0);
    applyStimulus(itype(6'h09, 16'h0001), 32'h7FFF_FFFF, 32'h0);
    checkAll("addiu_noovf", 32'h8000_0000, 3'b001, 32'h0, 32'h0);

    $display("[TB] multiply/divide");
    applyStimulus(rtype(6'h18, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);
    checkAll("mult", 32'h0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(rtype(6'h19, 5'd0), 32'hFFFF_FFFF, 32'h0000_0002);
    checkAll("multu", 32'h0, 3'b000, 32'h0000_0001, 32'hFFFF_FFFE);
    applyStimulus(rtype(6'h1A, 5'd0), 32'hFFFF_FFE1, 32'h0000_0011);
    checkAll("div", 32'h0, 3'b000, 32'hFFFF_FFF2, 32'hFFFF_FFFF);
    applyStimulus(rtype(6'h1B, 5'd0), 32'h0000_000D, 32'h0000_0001);
    checkAll("divu", 32'h0, 3'b000, 32'h0, 32'h0000_000D);
    applyStimulus(rtype(6'h1A, 5'd0), 32'h0000_0005, 32'h0);
    checkAll("div_by0", 32'h0, 3'b000, 32'h0, 32'h0000_000D);
    applyStimulus(rtype(6'h19, 5'd0), 32'h0001_0000, 32'h0003_0000);
    checkAll("multu_big", 32'h0, 3'b000, 32'h0000_0003, 32'h0);

    $display("[TB] logic ops and hold of hi/lo");
    applyStimulus(rtype(6'h24, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkAll("and", 32'hF000_F000, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h25, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkAll("or", 32'hFFF0_FFF0, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h23, 16'hFFFC), 32'h0000_1000, 32'h0);
    checkAll("lw", 32'h0000_0FFC, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h2B, 16'h0010), 32'h0000_1000, 32'h0);
    checkAll("sw", 32'h0000_1010, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h26, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkAll("xor", 32'h0FF0_0FF0, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h27, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkAll("nor", 32'h000F_000F, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h0C, 16'h8001), 32'hFFFF_FFFF, 32'h0);
    checkAll("andi", 32'h0000_8001, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h0D, 16'h8000), 32'h0, 32'h0);
    checkAll("ori", 32'h0000_8000, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h0E, 16'hFFFF), 32'hFFFF_0000, 32'h0);
    checkAll("xori", 32'hFFFF_FFFF, 3'b001, 32'h0000_0003, 32'h0);

    $display("[TB] compares and branches");
    applyStimulus(rtype(6'h2A, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD);
    checkAll("slt", 32'h0, 3'b100, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h2B, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD);
    checkAll("sltu", 32'h1, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h0A, 16'h000D), 32'h0000_0001, 32'h0);
    checkAll("slti", 32'h1, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h0A, 16'hFFFF), 32'h0000_0001, 32'h0);
    checkAll("slti_neg", 32'h0, 3'b100, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h0B, 16'hFFFF), 32'h0000_0001, 32'h0);
    checkAll("sltiu", 32'h1, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h05, 16'h0004), 32'h1234_5678, 32'h1234_5678);
    checkAll("bne_eq", 32'h0, 3'b100, 32'h0000_0003, 32'h0);
    applyStimulus(itype(6'h04, 16'h0004), 32'h0000_0005, 32'h0000_0003);
    checkAll("beq_ne", 32'h0000_0002, 3'b000, 32'h0000_0003, 32'h0);

    $display("[TB] shifts");
    applyStimulus(rtype(6'h00, 5'd1), 32'h0, 32'hDDDD_DDDD);
    checkAll("sll", 32'hBBBB_BBBA, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h02, 5'd1), 32'h0, 32'hDDDD_DDDD);
    checkAll("srl", 32'h6EEE_EEEE, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h03, 5'd1), 32'h0, 32'hDDDD_DDDD);
    checkAll("sra", 32'hEEEE_EEEE, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h07, 5'd0), 32'h0000_0002, 32'hDDDD_DDDD);
    checkAll("srav", 32'hF777_7777, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h04, 5'd0), 32'h0000_0024, 32'hDDDD_DDDD);
    checkAll("sllv", 32'hDDDD_DDD0, 3'b001, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h06, 5'd0), 32'h0000_0004, 32'hDDDD_DDDD);
    checkAll("srlv", 32'h0DDD_DDDD, 3'b000, 32'h0000_0003, 32'h0);

    $display("[TB] unsupported encodings");
    applyStimulus(itype(6'h3F, 16'h1234), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkAll("bad_op", 32'h0, 3'b000, 32'h0000_0003, 32'h0);
    applyStimulus(rtype(6'h20, 5'd0), 32'h0000_0001, 32'h0000_0001);
    checkOutput("pre_bad_func.c", c, 32'h0000_0002);
    applyStimulus(rtype(6'h3F, 5'd0), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkAll("bad_func", 32'h0, 3'b000, 32'h0000_0003, 32'h0);

    $display("[TB] asynchronous reset mid-sequence");
    applyStimulus(rtype(6'h18, 5'd0), 32'h0000_0010, 32'h1000_0001);
    checkAll("mult_pre_rst", 32'h0, 3'b000, 32'h0000_0001, 32'h0000_0010);
    applyStimulus(rtype(6'h21, 5'd0), 32'h0000_0100, 32'h0000_0023);
    checkOutput("pre_rst.c", c, 32'h0000_0123);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 32'h0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(rtype(6'h20, 5'd0), 32'h0000_0007, 32'h0000_0008);
    checkAll("post_rst", 32'h0000_000F, 3'b000, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
